vga_timing_generator: RTL and testbench

Parametrised raster timing generator for the VGA output path. It produces horizontal and vertical sync, blanking and pixel coordinates for any mode described by porch, sync and active-length parameters. It supports a pixel-clock-enable strobe, so one system clock can drive slower pixel rates, and a run/hold enable. It also emits line-start and frame-start strobes for the frame-buffer reader and pattern generators downstream.

---
 rtl/vga_timing_if.sv | 25 ++
 rtl/vga_timing_generator.sv | 126 ++++++++++++
 tb/tb_vga_timing_generator.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle: run controls toward the generator, sync/blank/coordinates/strobes back out.
interface vga_timing_if #(
  parameter int unsigned CW = 12
);
  logic          enable;
  logic          pixel_en;
  logic          blank_n;
  logic          hsync_n;
  logic          vsync_n;
  logic          sync_n;
  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  enable, pixel_en,
    output blank_n, hsync_n, vsync_n, sync_n, next_x, next_y, line_start, frame_start
  );

  modport slave (
    output enable, pixel_en,
    input  blank_n, hsync_n, vsync_n, sync_n, next_x, next_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster timing: h/v counters advanced by a pixel strobe, outputs
// registered from the decode of the pre-increment position.
module vga_timing_generator #(
  parameter int unsigned CW       = 12,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23
) (
  input logic          clk_i,
  input logic          rst_n_i,
  vga_timing_if.master vga_if
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  if (CW < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_illegal_mode
    $error("vga_timing_generator: illegal timing parameters");
  end

  logic          advance;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          h_act, v_act, h_syn, v_syn;

  logic          blank_n_q, blank_n_d;
  logic          hsync_n_q, hsync_n_d;
  logic          vsync_n_q, vsync_n_d;
  logic          sync_n_q, sync_n_d;
  logic [CW-1:0] next_x_q, next_x_d;
  logic [CW-1:0] next_y_q, next_y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  assign advance = vga_if.enable & vga_if.pixel_en;

  // Raster position: h wraps at the line total and carries into v.
  always_comb begin : counter_next
    h_d = h_q;
    v_d = v_q;
    if (advance) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  assign h_act = h_q < CW'(H_ACTIVE);
  assign v_act = v_q < CW'(V_ACTIVE);
  assign h_syn = (h_q >= CW'(H_SYNC_BEG)) && (h_q < CW'(H_SYNC_END));
  assign v_syn = (v_q >= CW'(V_SYNC_BEG)) && (v_q < CW'(V_SYNC_END));

  // Levels hold while stalled; strobes self-clear on every edge.
  always_comb begin : output_next
    blank_n_d     = blank_n_q;
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    sync_n_d      = sync_n_q;
    next_x_d      = next_x_q;
    next_y_d      = next_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (advance) begin
      blank_n_d     = h_act & v_act;
      hsync_n_d     = ~h_syn;
      vsync_n_d     = ~v_syn;
      sync_n_d      = ~h_syn & ~v_syn;
      next_x_d      = h_act ? h_q : '0;
      next_y_d      = v_act ? v_q : '0;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin : state_regs
    if (!rst_n_i) begin
      h_q           <= '0;
      v_q           <= '0;
      blank_n_q     <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      sync_n_q      <= 1'b1;
      next_x_q      <= '0;
      next_y_q      <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      blank_n_q     <= blank_n_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      sync_n_q      <= sync_n_d;
      next_x_q      <= next_x_d;
      next_y_q      <= next_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_if.blank_n     = blank_n_q;
  assign vga_if.hsync_n     = hsync_n_q;
  assign vga_if.vsync_n     = vsync_n_q;
  assign vga_if.sync_n      = sync_n_q;
  assign vga_if.next_x      = next_x_q;
  assign vga_if.next_y      = next_y_q;
  assign vga_if.line_start  = line_start_q;
  assign vga_if.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default mode, small-H/default-V mode and a tiny 8x6 mode,
// each checked every cycle against a linear-pixel-index reference model.
module tb_vga_timing_generator;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
  } mode_t;

  // out = {blank_n, hsync_n, vsync_n, sync_n, line_start, frame_start, next_x[11:0], next_y[11:0]}
  typedef struct {
    int          pos;
    logic [29:0] out;
  } model_t;

  localparam logic [29:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 24'd0};
  localparam logic [29:0] ORIGIN_VEC = {6'b111111, 24'd0};

  logic   clk;
  logic   rst_n;
  int     checks = 0;
  int     errors = 0;
  mode_t  mode_d, mode_m, mode_s;
  model_t md, mm, ms;

  vga_timing_if #(.CW(12)) vi_d ();
  vga_timing_if #(.CW(12)) vi_m ();
  vga_timing_if #(.CW(4))  vi_s ();

  vga_timing_generator #(.CW(12)) u_dut_d (
    .clk_i(clk), .rst_n_i(rst_n), .vga_if(vi_d.master)
  );

  vga_timing_generator #(
    .CW(12), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) u_dut_m (
    .clk_i(clk), .rst_n_i(rst_n), .vga_if(vi_m.master)
  );

  vga_timing_generator #(
    .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .vga_if(vi_s.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the frame is a linear sequence of pixels; each advance presents the next one.
  function automatic model_t step_model(input model_t m, input bit adv, input mode_t mo);
    model_t r;
    int ht, vt, x, y;
    bit hact, vact, hsy, vsy;
    r = m;
    r.out[25] = 1'b0;
    r.out[24] = 1'b0;
    if (adv) begin
      ht   = mo.ha + mo.hf + mo.hsw + mo.hb;
      vt   = mo.va + mo.vf + mo.vsw + mo.vb;
      x    = m.pos % ht;
      y    = m.pos / ht;
      hact = x < mo.ha;
      vact = y < mo.va;
      hsy  = (x >= mo.ha + mo.hf) && (x < mo.ha + mo.hf + mo.hsw);
      vsy  = (y >= mo.va + mo.vf) && (y < mo.va + mo.vf + mo.vsw);
      r.out = {hact && vact, !hsy, !vsy, !hsy && !vsy, x == 0, (x == 0) && (y == 0),
               12'(hact ? x : 0), 12'(vact ? y : 0)};
      r.pos = (m.pos + 1) % (ht * vt);
    end
    return r;
  endfunction

  function automatic logic [29:0] obs_d();
    return {vi_d.blank_n, vi_d.hsync_n, vi_d.vsync_n, vi_d.sync_n, vi_d.line_start,
            vi_d.frame_start, vi_d.next_x, vi_d.next_y};
  endfunction

  function automatic logic [29:0] obs_m();
    return {vi_m.blank_n, vi_m.hsync_n, vi_m.vsync_n, vi_m.sync_n, vi_m.line_start,
            vi_m.frame_start, vi_m.next_x, vi_m.next_y};
  endfunction

  function automatic logic [29:0] obs_s();
    return {vi_s.blank_n, vi_s.hsync_n, vi_s.vsync_n, vi_s.sync_n, vi_s.line_start,
            vi_s.frame_start, 12'(vi_s.next_x), 12'(vi_s.next_y)};
  endfunction

  // One clock: inputs as held across the edge drive all three models.
  task automatic cycle();
    bit ad, am, as;
    ad = vi_d.enable & vi_d.pixel_en;
    am = vi_m.enable & vi_m.pixel_en;
    as = vi_s.enable & vi_s.pixel_en;
    @(posedge clk);
    #1;
    if (rst_n) begin
      md = step_model(md, ad, mode_d);
      mm = step_model(mm, am, mode_m);
      ms = step_model(ms, as, mode_s);
    end
  endtask

  task automatic test_reset();
    logic [29:0] o;
    checks++; if (obs_d() !== RESET_VEC) begin errors++; $display("FAIL reset_d: got %h expected %h", obs_d(), RESET_VEC); end
    checks++; if (obs_m() !== RESET_VEC) begin errors++; $display("FAIL reset_m: got %h expected %h", obs_m(), RESET_VEC); end
    checks++; if (obs_s() !== RESET_VEC) begin errors++; $display("FAIL reset_s: got %h expected %h", obs_s(), RESET_VEC); end
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      cycle();
      checks++; if (obs_d() !== md.out) begin errors++; $display("FAIL run_d c=%0d: got %h expected %h", c, obs_d(), md.out); end
    end
    // Asynchronous reset mid-line, well away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs_d() !== RESET_VEC) begin errors++; $display("FAIL async_reset_d: got %h expected %h", obs_d(), RESET_VEC); end
    checks++; if (obs_m() !== RESET_VEC) begin errors++; $display("FAIL async_reset_m: got %h expected %h", obs_m(), RESET_VEC); end
    checks++; if (obs_s() !== RESET_VEC) begin errors++; $display("FAIL async_reset_s: got %h expected %h", obs_s(), RESET_VEC); end
    md = '{0, RESET_VEC};
    mm = '{0, RESET_VEC};
    ms = '{0, RESET_VEC};
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle();
    checks++; if (obs_d() !== ORIGIN_VEC) begin errors++; $display("FAIL first_edge_d: got %h expected %h", obs_d(), ORIGIN_VEC); end
    checks++; if (obs_s() !== ORIGIN_VEC) begin errors++; $display("FAIL first_edge_s: got %h expected %h", obs_s(), ORIGIN_VEC); end
    checks++; if (obs_d() !== md.out) begin errors++; $display("FAIL first_edge_model_d: got %h expected %h", obs_d(), md.out); end
    cycle();
    o = obs_d();
    checks++; if (o[25:24] !== 2'b00) begin errors++; $display("FAIL strobes_clear: got %b expected 00", o[25:24]); end
    checks++; if (vi_d.next_x !== 12'd1) begin errors++; $display("FAIL second_edge_x: got %0d expected 1", vi_d.next_x); end
  endtask

  task automatic test_default_line();
    logic [29:0] o, p;
    int last_ls, hs_start, n_ls;
    last_ls = -1; hs_start = -1; n_ls = 0;
    vi_d.enable = 1'b1; vi_d.pixel_en = 1'b1;
    p = obs_d();
    for (int c = 0; c < 3 * 1040 + 5; c++) begin
      cycle();
      o = obs_d();
      checks++; if (o !== md.out) begin errors++; $display("FAIL line_d c=%0d: got %h expected %h", c, o, md.out); end
      if (o[25]) begin
        if (last_ls >= 0) begin
          checks++; if (c - last_ls != 1040) begin errors++; $display("FAIL line_period: got %0d expected 1040", c - last_ls); end
        end
        last_ls = c; n_ls++;
      end
      if (p[28] && !o[28]) begin
        hs_start = c;
        if (last_ls >= 0) begin
          checks++; if (c - last_ls != 856) begin errors++; $display("FAIL hsync_offset: got %0d expected 856", c - last_ls); end
        end
      end
      if (!p[28] && o[28] && hs_start >= 0) begin
        checks++; if (c - hs_start != 120) begin errors++; $display("FAIL hsync_width: got %0d expected 120", c - hs_start); end
      end
      if (p[29] && !o[29]) begin
        checks++; if (p[23:12] !== 12'd799) begin errors++; $display("FAIL blank_edge: got last x %0d expected 799", p[23:12]); end
      end
      p = o;
    end
    checks++; if (n_ls < 3) begin errors++; $display("FAIL line_count: got %0d expected at least 3", n_ls); end
  endtask

  task automatic test_pixel_en_toggle();
    logic [29:0] o, p;
    int last_ls, n_per;
    last_ls = -1; n_per = 0;
    vi_d.enable = 1'b1;
    p = obs_d();
    for (int c = 0; c < 3 * 2080 + 10; c++) begin
      vi_d.pixel_en = (c % 2 == 0);
      cycle();
      o = obs_d();
      checks++; if (o !== md.out) begin errors++; $display("FAIL toggle_d c=%0d: got %h expected %h", c, o, md.out); end
      if (p[25]) begin
        checks++; if (o[25] !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", o[25]); end
      end
      if (o[25]) begin
        if (last_ls >= 0) begin
          n_per++;
          checks++; if (c - last_ls != 2080) begin errors++; $display("FAIL toggle_period: got %0d expected 2080", c - last_ls); end
        end
        last_ls = c;
      end
      p = o;
    end
    checks++; if (n_per < 2) begin errors++; $display("FAIL toggle_count: got %0d expected at least 2", n_per); end
    vi_d.pixel_en = 1'b1;
  endtask

  task automatic test_enable_hold();
    bit found;
    found = 1'b0;
    vi_d.enable = 1'b1; vi_d.pixel_en = 1'b1;
    for (int c = 0; c < 2200 && !found; c++) begin
      cycle();
      checks++; if (obs_d() !== md.out) begin errors++; $display("FAIL seek_d c=%0d: got %h expected %h", c, obs_d(), md.out); end
      if (md.out[23:12] == 12'd400) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL seek_timeout: got no x=400 expected x=400 within 2200 clocks"); end
    vi_d.enable = 1'b0;
    for (int c = 0; c < 37; c++) begin
      cycle();
      checks++; if (obs_d() !== md.out) begin errors++; $display("FAIL hold_d c=%0d: got %h expected %h", c, obs_d(), md.out); end
    end
    checks++; if (vi_d.next_x !== 12'd400 || vi_d.blank_n !== 1'b1) begin
      errors++; $display("FAIL hold_x: got x=%0d blank=%b expected x=400 blank=1", vi_d.next_x, vi_d.blank_n);
    end
    vi_d.enable = 1'b1;
    cycle();
    checks++; if (vi_d.next_x !== 12'd401) begin errors++; $display("FAIL resume_x: got %0d expected 401", vi_d.next_x); end
    checks++; if (obs_d() !== md.out) begin errors++; $display("FAIL resume_d: got %h expected %h", obs_d(), md.out); end
  endtask

  task automatic test_default_frame();
    logic [29:0] o, p;
    int last_fs, vs_start, n_vs;
    last_fs = -1; vs_start = -1; n_vs = 0;
    vi_m.enable = 1'b1; vi_m.pixel_en = 1'b1;
    p = obs_m();
    for (int c = 0; c < 2 * 5328 + 20; c++) begin
      cycle();
      o = obs_m();
      checks++; if (o !== mm.out) begin errors++; $display("FAIL frame_m c=%0d: got %h expected %h", c, o, mm.out); end
      checks++; if (o[26] !== (o[28] & o[27])) begin errors++; $display("FAIL composite_sync c=%0d: got %b expected %b", c, o[26], o[28] & o[27]); end
      if (o[24]) begin
        if (last_fs >= 0) begin
          checks++; if (c - last_fs != 5328) begin errors++; $display("FAIL frame_period: got %0d expected 5328", c - last_fs); end
        end
        last_fs = c;
      end
      if (p[27] && !o[27]) begin
        vs_start = c;
        if (last_fs >= 0) begin
          n_vs++;
          checks++; if (c - last_fs != 637 * 8) begin errors++; $display("FAIL vsync_offset: got %0d expected %0d", c - last_fs, 637 * 8); end
        end
      end
      if (!p[27] && o[27] && vs_start >= 0) begin
        checks++; if (c - vs_start != 6 * 8) begin errors++; $display("FAIL vsync_width: got %0d expected 48", c - vs_start); end
      end
      p = o;
    end
    checks++; if (n_vs < 1) begin errors++; $display("FAIL vsync_seen: got %0d expected at least 1", n_vs); end
  endtask

  task automatic test_small_random();
    int adv, dut_fs, exp_fs, c;
    adv = 0; dut_fs = 0; exp_fs = 0; c = 0;
    while (adv < 3 * 48 + 10 && c < 2000) begin
      vi_s.enable   = ($urandom_range(0, 9) != 0);
      vi_s.pixel_en = ($urandom_range(0, 1) != 0);
      if (vi_s.enable && vi_s.pixel_en) adv++;
      cycle();
      checks++; if (obs_s() !== ms.out) begin errors++; $display("FAIL small_s c=%0d: got %h expected %h", c, obs_s(), ms.out); end
      if (vi_s.frame_start) dut_fs++;
      if (ms.out[24]) exp_fs++;
      c++;
    end
    checks++; if (adv < 3 * 48 + 10) begin errors++; $display("FAIL small_timeout: got %0d advances expected %0d", adv, 3 * 48 + 10); end
    checks++; if (dut_fs != exp_fs) begin errors++; $display("FAIL small_frames: got %0d expected %0d", dut_fs, exp_fs); end
  endtask

  initial begin
    mode_d = '{800, 56, 120, 64, 600, 37, 6, 23};
    mode_m = '{4, 1, 2, 1, 600, 37, 6, 23};
    mode_s = '{4, 1, 2, 1, 3, 1, 1, 1};
    md = '{0, RESET_VEC};
    mm = '{0, RESET_VEC};
    ms = '{0, RESET_VEC};
    rst_n = 1'b0;
    vi_d.enable = 1'b1; vi_d.pixel_en = 1'b1;
    vi_m.enable = 1'b1; vi_m.pixel_en = 1'b1;
    vi_s.enable = 1'b1; vi_s.pixel_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_default_line();
    test_pixel_en_toggle();
    test_enable_hold();
    test_default_frame();
    test_small_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
